// File: rtl/pc_stack_unit.sv
// Program counter with relative branching and a hardware return-address stack.
// All outputs come straight from registers; MODE/DIN only affect the next edge.
module pc_stack_unit #(
  parameter int unsigned     WIDTH        = 16,
  parameter int unsigned     STACK_DEPTH  = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           EN,
  input  logic [2:0]                     MODE,
  input  logic [WIDTH-1:0]               DIN,
  output logic [WIDTH-1:0]               DOUT,
  output logic [$clog2(STACK_DEPTH):0]   STACK_LEVEL,
  output logic                           OVERFLOW,
  output logic                           UNDERFLOW
);

  localparam int unsigned AddrW  = $clog2(STACK_DEPTH);
  localparam int unsigned LevelW = AddrW + 1;

  localparam logic [2:0] ModeHold     = 3'd0;
  localparam logic [2:0] ModeInc      = 3'd1;
  localparam logic [2:0] ModeLoad     = 3'd2;
  localparam logic [2:0] ModeRel      = 3'd3;
  localparam logic [2:0] ModeCall     = 3'd4;
  localparam logic [2:0] ModeRet      = 3'd5;
  localparam logic [2:0] ModeClrStack = 3'd6;

  localparam logic [LevelW-1:0] LevelFull = LevelW'(STACK_DEPTH);

  logic [WIDTH-1:0]  stackMem [STACK_DEPTH];

  logic [WIDTH-1:0]  pcNext;
  logic [LevelW-1:0] levelNext;
  logic              overflowNext;
  logic              underflowNext;
  logic              pushEn;
  logic [WIDTH-1:0]  returnAddr;
  logic [AddrW-1:0]  pushIdx;
  logic [AddrW-1:0]  topIdx;
  logic              stackFull;
  logic              stackEmpty;

  // Stack addressing: level counter doubles as the push slot; top is one below.
  always_comb begin
    returnAddr = DOUT + WIDTH'(1);
    pushIdx    = STACK_LEVEL[AddrW-1:0];
    topIdx     = AddrW'(STACK_LEVEL - LevelW'(1));
    stackFull  = (STACK_LEVEL == LevelFull);
    stackEmpty = (STACK_LEVEL == '0);
  end

  // Next-state decode for PC, level counter and sticky error flags.
  always_comb begin
    pcNext        = DOUT;
    levelNext     = STACK_LEVEL;
    overflowNext  = OVERFLOW;
    underflowNext = UNDERFLOW;
    pushEn        = 1'b0;
    if (EN) begin
      case (MODE)
        ModeHold: ;
        ModeInc:  pcNext = DOUT + WIDTH'(1);
        ModeLoad: pcNext = DIN;
        ModeRel:  pcNext = DOUT + DIN;
        ModeCall: begin
          if (stackFull) begin
            overflowNext = 1'b1;
          end else begin
            pushEn    = 1'b1;
            pcNext    = DIN;
            levelNext = STACK_LEVEL + LevelW'(1);
          end
        end
        ModeRet: begin
          if (stackEmpty) begin
            underflowNext = 1'b1;
          end else begin
            pcNext    = stackMem[topIdx];
            levelNext = STACK_LEVEL - LevelW'(1);
          end
        end
        ModeClrStack: levelNext = '0;
        default: ;
      endcase
    end
  end

  // Architectural registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DOUT        <= RESET_VECTOR;
      STACK_LEVEL <= '0;
      OVERFLOW    <= 1'b0;
      UNDERFLOW   <= 1'b0;
    end else begin
      DOUT        <= pcNext;
      STACK_LEVEL <= levelNext;
      OVERFLOW    <= overflowNext;
      UNDERFLOW   <= underflowNext;
    end
  end

  // Return-address storage; contents are irrelevant after reset so it is not cleared.
  always_ff @(posedge CLK) begin
    if (!RST && pushEn) begin
      stackMem[pushIdx] <= returnAddr;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: queue-based reference model checked every
// cycle, plus literal expectations taken from hand-worked sequences.
module tb_pc_stack_unit;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 8;
  localparam logic [W-1:0] RV   = 16'h0000;

  localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, LOAD = 3'd2, REL = 3'd3,
                         CALL = 3'd4, RET = 3'd5, CLRS = 3'd6, RSVD = 3'd7;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         EN = 1'b0;
  logic [2:0]   MODE = 3'd0;
  logic [W-1:0] DIN = '0;
  logic [W-1:0] DOUT;
  logic [3:0]   STACK_LEVEL;
  logic         OVERFLOW;
  logic         UNDERFLOW;

  int vectors = 0;
  int miscompares = 0;

  pc_stack_unit #(.WIDTH(W), .STACK_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .DIN(DIN),
    .DOUT(DOUT), .STACK_LEVEL(STACK_LEVEL), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  // Reference model: plain integer arithmetic and a queue used as the LIFO.
  int          mPc = 0;
  int          mStack[$];
  bit          mOvf = 0;
  bit          mUnf = 0;
  bit          modelValid = 0;

  always @(posedge CLK) begin
    if (RST) begin
      mPc = int'(RV);
      mStack.delete();
      mOvf = 0;
      mUnf = 0;
      modelValid = 1;
    end else if (EN) begin
      case (MODE)
        INC:  mPc = (mPc + 1) % 65536;
        LOAD: mPc = int'(DIN);
        REL:  mPc = (mPc + int'(DIN)) % 65536;
        CALL: if (mStack.size() >= DEPTH) mOvf = 1;
              else begin
                mStack.push_back((mPc + 1) % 65536);
                mPc = int'(DIN);
              end
        RET:  if (mStack.size() == 0) mUnf = 1;
              else mPc = mStack.pop_back();
        CLRS: mStack.delete();
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (modelValid) begin
      check("model.DOUT",        int'(DOUT),        mPc);
      check("model.STACK_LEVEL", int'(STACK_LEVEL), mStack.size());
      check("model.OVERFLOW",    int'(OVERFLOW),    int'(mOvf));
      check("model.UNDERFLOW",   int'(UNDERFLOW),   int'(mUnf));
    end
  end

  // Apply one operation for exactly one rising edge, then sample just after it.
  task automatic op(input logic rst, input logic en, input logic [2:0] mode,
                    input logic [W-1:0] din);
    @(negedge CLK);
    RST = rst; EN = en; MODE = mode; DIN = din;
    @(posedge CLK);
    #1;
  endtask

  task automatic lit(input string name, input int dout, input int lvl,
                     input int ovf, input int unf);
    check({name, ".DOUT"},  int'(DOUT),        dout);
    check({name, ".LEVEL"}, int'(STACK_LEVEL), lvl);
    check({name, ".OVF"},   int'(OVERFLOW),    ovf);
    check({name, ".UNF"},   int'(UNDERFLOW),   unf);
  endtask

  initial begin
    // 1: reset and increment wrap
    op(1, 0, HOLD, 16'h0000);  lit("reset", 16'h0000, 0, 0, 0);
    op(0, 1, LOAD, 16'hFFFE);  lit("load", 16'hFFFE, 0, 0, 0);
    op(0, 1, INC, 16'h0000);   lit("inc1", 16'hFFFF, 0, 0, 0);
    op(0, 1, INC, 16'h0000);   lit("inc2", 16'h0000, 0, 0, 0);
    op(0, 1, INC, 16'h0000);   lit("inc3", 16'h0001, 0, 0, 0);

    // 2: relative branches, both wrap directions
    op(0, 1, LOAD, 16'h0010);
    op(0, 1, REL, 16'hFFF0);   lit("rel1", 16'h0000, 0, 0, 0);
    op(0, 1, REL, 16'h0005);   lit("rel2", 16'h0005, 0, 0, 0);
    op(0, 1, REL, 16'hFFF0);   lit("rel3", 16'hFFF5, 0, 0, 0);

    // 3: nested calls and returns
    op(0, 1, LOAD, 16'h0100);
    op(0, 1, CALL, 16'h2000);  lit("call1", 16'h2000, 1, 0, 0);
    op(0, 1, CALL, 16'h3000);  lit("call2", 16'h3000, 2, 0, 0);
    op(0, 1, RET, 16'h0000);   lit("ret1", 16'h2001, 1, 0, 0);
    op(0, 1, RET, 16'h0000);   lit("ret2", 16'h0101, 0, 0, 0);

    // Return address wraps when calling from all-ones
    op(0, 1, LOAD, 16'hFFFF);
    op(0, 1, CALL, 16'h1234);  lit("callwrap", 16'h1234, 1, 0, 0);
    op(0, 1, RET, 16'h0000);   lit("retwrap", 16'h0000, 0, 0, 0);

    // 4: fill the stack, overflow, drain
    op(0, 1, LOAD, 16'h0000);
    for (int k = 1; k <= 8; k++) op(0, 1, CALL, W'(k));
    lit("full", 16'h0008, 8, 0, 0);
    op(0, 1, CALL, 16'h00AA);  lit("ovf", 16'h0008, 8, 1, 0);
    for (int k = 8; k >= 1; k--) begin
      op(0, 1, RET, 16'h0000);
      check("drain.DOUT", int'(DOUT), k);
      check("drain.LEVEL", int'(STACK_LEVEL), k - 1);
    end
    lit("drained", 16'h0001, 0, 1, 0);

    // 5: underflow, enable gating, reserved mode
    op(0, 1, LOAD, 16'h1234);
    op(0, 1, RET, 16'h0000);   lit("unf", 16'h1234, 0, 1, 1);
    for (int i = 0; i < 4; i++) op(0, 0, INC, 16'h0000);
    lit("en0", 16'h1234, 0, 1, 1);
    op(0, 0, CALL, 16'h5555);  lit("en0call", 16'h1234, 0, 1, 1);
    op(0, 1, RSVD, 16'hBEEF);  lit("mode7", 16'h1234, 0, 1, 1);

    // 6: reset beats a simultaneous CALL; CLRSTACK keeps PC and flags
    op(0, 1, CALL, 16'h0A00);
    op(0, 1, CALL, 16'h0B00);
    op(0, 1, CALL, 16'h0C00);  lit("pre_rst", 16'h0C00, 3, 1, 1);
    op(1, 1, CALL, 16'h4000);  lit("rst_call", 16'h0000, 0, 0, 0);
    for (int k = 1; k <= 5; k++) op(0, 1, CALL, W'(16'h0700 + k));
    lit("five", 16'h0705, 5, 0, 0);
    op(0, 1, CLRS, 16'h0000);  lit("clrs", 16'h0705, 0, 0, 0);
    op(0, 1, RET, 16'h0000);   lit("clrs_ret", 16'h0705, 0, 0, 1);
    op(0, 1, HOLD, 16'h0000);  lit("hold", 16'h0705, 0, 0, 1);

    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a runaway simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised next-generation program counter for the TTL16 CPU.
- Adds a configurable datapath width, relative branching, and a hardware return-address stack for CALL/RET.
- Sits between the instruction decoder, which supplies MODE and DIN, and instruction fetch, which consumes DOUT.
- All state updates on the rising edge of CLK.

Parameters:
WIDTH, 16, bit width of PC, DIN, DOUT and each stack entry (WIDTH >= 2)
STACK_DEPTH, 8, number of return-address entries (power of two, >= 2)
RESET_VECTOR, 0, value loaded into the PC on reset (WIDTH bits)

Ports:
CLK  input  1  system clock; all state changes on rising edge
RST  input  1  synchronous, active-high reset
EN  input  1  update enable; when 0, all state holds regardless of MODE
MODE  input  3  operation select (encoding below)
DIN  input  WIDTH  absolute target (LOAD/CALL) or two's-complement offset (REL)
DOUT  output  WIDTH  current PC value, driven directly from the PC register
STACK_LEVEL  output  $clog2(STACK_DEPTH)+1  number of valid stack entries, 0..STACK_DEPTH
OVERFLOW  output  1  sticky; set by CALL on a full stack
UNDERFLOW  output  1  sticky; set by RET on an empty stack

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - On a CLK edge with RST=1: DOUT=RESET_VECTOR, STACK_LEVEL=0, OVERFLOW=0, UNDERFLOW=0.
  - Stack contents are don't-care after reset.
  - RST has priority over EN and MODE.
  - RST asserted mid-sequence, including on the same edge as a CALL, discards that operation entirely.
- Enable: on an edge with RST=0 and EN=0, nothing changes.
- MODE encoding (evaluated on an edge with RST=0, EN=1):
  - 0 HOLD: no change.
  - 1 INC: DOUT <= DOUT+1.
  - 2 LOAD: DOUT <= DIN.
  - 3 REL: DOUT <= DOUT+DIN, with DIN treated as signed.
  - 4 CALL: push DOUT+1; DOUT <= DIN; STACK_LEVEL+1.
  - 5 RET: DOUT <= top of stack; pop; STACK_LEVEL-1.
  - 6 CLRSTACK: STACK_LEVEL <= 0. DOUT, OVERFLOW and UNDERFLOW are unchanged.
  - 7 reserved: behaves as HOLD.
- Arithmetic:
  - All PC arithmetic is modulo 2^WIDTH with no carry or flag.
  - INC from all-ones gives 0.
  - REL wraps in both directions.
  - The pushed return address DOUT+1 also wraps; CALL at all-ones pushes 0.
- Stack:
  - LIFO, implemented as a register array with a level counter.
  - The new value becomes visible on DOUT and STACK_LEVEL one edge after the operation, i.e. latency 1 cycle. No combinational path from MODE or DIN to any output.
- CALL with STACK_LEVEL == STACK_DEPTH:
  - No push, no jump; DOUT and STACK_LEVEL unchanged.
  - OVERFLOW <= 1.
  - The oldest entry is never overwritten.
- RET with STACK_LEVEL == 0:
  - DOUT and STACK_LEVEL unchanged.
  - UNDERFLOW <= 1.
- Error flags: OVERFLOW and UNDERFLOW stay set until RST. No other operation clears them.
- Back-to-back operations:
  - CALL then RET on consecutive edges is legal and returns to the pre-CALL DOUT+1.
  - Any mix of operations on consecutive cycles needs no stall cycles.
- Outputs are registered only; no X on any output after the first reset edge.

Test Plan:
1. Reset/increment: WIDTH=16; reset, LOAD 0xFFFE, INC ×3 -> DOUT 0xFFFF, 0x0000, 0x0001; STACK_LEVEL=0; flags 0.
2. Relative branch: LOAD 0x0010; REL DIN=0xFFF0 (-16) -> DOUT=0x0000; REL DIN=0x0005 -> 0x0005; REL DIN=0xFFF0 from 0x0005 -> 0xFFF5.
3. Nested calls:
   - Stimulus: LOAD 0x0100; CALL 0x2000; CALL 0x3000.
   - Required: DOUT=0x3000, STACK_LEVEL=2.
   - Then RET -> DOUT=0x2001, STACK_LEVEL=1; RET -> DOUT=0x0101, STACK_LEVEL=0.
4. Overflow:
   - Stimulus: STACK_DEPTH=8; 8 CALLs, the k-th (k=1..8) with DIN=k, starting from DOUT=0x0000 -> STACK_LEVEL=8, DOUT=0x0008, OVERFLOW=0.
   - 9th CALL (DIN=0x00AA) -> DOUT=0x0008, STACK_LEVEL=8, OVERFLOW=1.
   - 8 RETs -> DOUT sequence 0x0008, 0x0007, ..., 0x0001; OVERFLOW still 1.
5. Underflow/enable:
   - RET on empty stack at DOUT=0x1234 -> DOUT=0x1234, UNDERFLOW=1.
   - EN=0 with MODE=INC for 4 cycles -> DOUT unchanged.
   - MODE=7 -> DOUT unchanged.
6. Reset priority:
   - RST=1 on the same edge as CALL 0x4000 at STACK_LEVEL=3 with both flags set -> DOUT=RESET_VECTOR, STACK_LEVEL=0, OVERFLOW=0, UNDERFLOW=0.
   - CLRSTACK from STACK_LEVEL=5 -> STACK_LEVEL=0, DOUT unchanged.
